// File: rtl/ddr2_sdram_ex_lfsr_checker_pkg.sv
// ddr2_sdram_ex_lfsr_checker_pkg: shared lane width, LFSR taps, checker FSM states and LFSR step.
package ddr2_sdram_ex_lfsr_checker_pkg;
  localparam int LANE_W = 8;
  localparam logic [LANE_W-1:0] TAP_MASK = 8'h1D;
  typedef enum logic [1:0] {IDLE, CHECK, FIN} state_t;
  function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] c);
    return {c[LANE_W-2:0], 1'b0} ^ (c[LANE_W-1] ? TAP_MASK : '0);
  endfunction
endpackage

// File: rtl/ddr2_sdram_ex_exp_lane.sv
// ddr2_sdram_ex_exp_lane: one byte lane of expected read data, an x^8+x^4+x^3+x^2+1 LFSR.
module ddr2_sdram_ex_exp_lane
  import ddr2_sdram_ex_lfsr_checker_pkg::*;
#(
  parameter logic [LANE_W-1:0] SEED = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  output logic [LANE_W-1:0] data
);
  logic [LANE_W-1:0] data_q, data_d;
  always_comb data_d = load ? SEED : advance ? lfsr_step(data_q) : data_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) data_q <= SEED;
    else data_q <= data_d;
  assign data = data_q;
endmodule

// File: rtl/ddr2_sdram_ex_lfsr_checker.sv
// ddr2_sdram_ex_lfsr_checker: compares read beats against per-lane LFSR patterns and
// reports pass, sticky lane errors, saturating error-beat count and first failing beat.
module ddr2_sdram_ex_lfsr_checker
  import ddr2_sdram_ex_lfsr_checker_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int SEED          = 32,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int NUM_LANES    = DATA_WIDTH / LANE_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [15:0]              num_beats,
  input  logic                     rdata_valid,
  input  logic [DATA_WIDTH-1:0]    rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [NUM_LANES-1:0]     byte_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic                     first_err_valid,
  output logic [15:0]              first_err_beat
);
  state_t                   state_q, state_d;
  logic [15:0]              num_q, num_d, beat_q, beat_d, feb_q, feb_d;
  logic                     busy_q, busy_d, done_q, done_d, pass_q, pass_d, fev_q, fev_d;
  logic [NUM_LANES-1:0]     be_q, be_d, mism;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     accept, last;
  // start has priority over a beat arriving in the same cycle
  assign accept = state_q == CHECK && rdata_valid && !start;
  assign last   = beat_q == num_q - 16'd1;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [LANE_W-1:0] exp_b;
    ddr2_sdram_ex_exp_lane #(.SEED(LANE_W'((SEED + g) % 256))) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (start),
      .advance (accept),
      .data    (exp_b)
    );
    assign mism[g] = exp_b != rdata[LANE_W*g +: LANE_W];
  end
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    beat_d  = beat_q;
    feb_d   = feb_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fev_d   = fev_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = num_beats == 16'd0 ? FIN : CHECK;
      num_d   = num_beats;
      beat_d  = '0;
      feb_d   = '0;
      fev_d   = 1'b0;
      be_d    = '0;
      cnt_d   = '0;
      busy_d  = num_beats != 16'd0;
      done_d  = num_beats == 16'd0;
      pass_d  = num_beats == 16'd0;
    end else if (accept) begin
      be_d   = be_q | mism;
      cnt_d  = |mism && !(&cnt_q) ? cnt_q + ERR_CNT_WIDTH'(1) : cnt_q;
      fev_d  = fev_q | (|mism);
      feb_d  = |mism && !fev_q ? beat_q : feb_q;
      beat_d = beat_q + 16'd1;
      if (last) begin
        state_d = FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = !fev_q && !(|mism);
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      num_q   <= '0;
      beat_q  <= '0;
      feb_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fev_q   <= 1'b0;
      be_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      beat_q  <= beat_d;
      feb_q   <= feb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fev_q   <= fev_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
    end
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign byte_err        = be_q;
  assign err_cnt         = cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_beat  = feb_q;
endmodule

// File: tb/tb_ddr2_sdram_ex_lfsr_checker.sv
// tb_ddr2_sdram_ex_lfsr_checker: scenario tasks plus randomized runs against a
// beat-list reference model of the read-data checker (16-bit data, 2-bit error counter).
module tb_ddr2_sdram_ex_lfsr_checker;
  localparam int DW = 16;
  localparam int NL = DW / 8;
  localparam int EW = 2;
  localparam int CNT_MAX = (1 << EW) - 1;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, rdata_valid = 1'b0;
  logic [15:0] num_beats = '0;
  logic [DW-1:0] rdata = '0;
  logic busy, done, pass, first_err_valid;
  logic [NL-1:0] byte_err;
  logic [EW-1:0] err_cnt;
  logic [15:0] first_err_beat;
  int checks = 0, failures = 0, done_seen = 0, gap_max = 0;
  logic [DW-1:0] beats[$];
  logic [NL-1:0] m_be;
  int m_cnt, m_feb;
  logic m_fev, m_pass;

  ddr2_sdram_ex_lfsr_checker #(.DATA_WIDTH(DW), .SEED(32), .ERR_CNT_WIDTH(EW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .num_beats       (num_beats),
    .rdata_valid     (rdata_valid),
    .rdata           (rdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .byte_err        (byte_err),
    .err_cnt         (err_cnt),
    .first_err_valid (first_err_valid),
    .first_err_beat  (first_err_beat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_seen++;
  end

  // k-th pattern byte of a lane: shift left, fold the dropped top bit back through 0x1D
  function automatic logic [7:0] exp_byte(input int lane, input int k);
    int v = (32 + lane) % 256;
    for (int j = 0; j < k; j++) v = ((v * 2) % 256) ^ (v >= 128 ? 'h1D : 0);
    return v[7:0];
  endfunction

  function automatic logic [DW-1:0] good_beat(input int k);
    return {exp_byte(1, k), exp_byte(0, k)};
  endfunction

  task automatic model();
    logic bad;
    m_be = '0; m_cnt = 0; m_fev = 1'b0; m_feb = 0;
    foreach (beats[k]) begin
      bad = 1'b0;
      for (int i = 0; i < NL; i++)
        if (beats[k][8*i +: 8] != exp_byte(i, k)) begin
          m_be[i] = 1'b1;
          bad = 1'b1;
        end
      if (bad) m_cnt = m_cnt < CNT_MAX ? m_cnt + 1 : CNT_MAX;
      if (bad && !m_fev) begin
        m_fev = 1'b1;
        m_feb = k;
      end
    end
    m_pass = !m_fev;
  endtask

  task automatic good_list(input int n);
    beats.delete();
    for (int k = 0; k < n; k++) beats.push_back(good_beat(k));
  endtask

  task automatic start_run(input int n);
    @(negedge clk);
    start = 1'b1;
    num_beats = 16'(n);
    rdata_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed();
    foreach (beats[k]) begin
      repeat ($urandom_range(gap_max)) begin
        rdata_valid = 1'b0;
        rdata = DW'($urandom);
        @(negedge clk);
      end
      rdata_valid = 1'b1;
      rdata = beats[k];
      @(negedge clk);
    end
    rdata_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, pass, first_err_valid, byte_err, err_cnt, first_err_beat} !== '0) begin
      failures++;
      $display("FAIL reset_values got=%h expected=0", {busy, done, pass, first_err_valid, byte_err, err_cnt, first_err_beat});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, pass} !== 3'b000) begin
      failures++;
      $display("FAIL after_release got=%b expected=000", {busy, done, pass});
    end
  endtask

  task automatic test_clean();
    repeat (3) begin
      rdata_valid = 1'b1;
      rdata = DW'($urandom);
      @(negedge clk);
    end
    rdata_valid = 1'b0;
    gap_max = 0;
    good_list(4);
    model();
    done_seen = 0;
    start_run(4);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL clean_busy got=%b expected=1", busy);
    end
    feed();
    checks++;
    if ({done, busy} !== 2'b10) begin
      failures++;
      $display("FAIL clean_done_timing got done,busy=%b expected=10", {done, busy});
    end
    checks++;
    if ({pass, byte_err, err_cnt, first_err_valid} !== {1'b1, NL'(0), EW'(0), 1'b0} ||
        {pass, byte_err, err_cnt, first_err_valid} !== {m_pass, m_be, EW'(m_cnt), m_fev}) begin
      failures++;
      $display("FAIL clean_flags got=%b expected=%b", {pass, byte_err, err_cnt, first_err_valid}, {m_pass, m_be, EW'(m_cnt), m_fev});
    end
    repeat (3) begin
      rdata_valid = 1'b1;
      rdata = 16'h0000;
      @(negedge clk);
    end
    rdata_valid = 1'b0;
    checks++;
    if ({done_seen, pass, byte_err, err_cnt} !== {32'd1, 1'b1, NL'(0), EW'(0)}) begin
      failures++;
      $display("FAIL clean_fin_hold got dones=%0d pass=%b be=%b cnt=%0d expected dones=1 pass=1 be=0 cnt=0", done_seen, pass, byte_err, err_cnt);
    end
  endtask

  task automatic test_lane_error();
    good_list(4);
    beats[2] = 16'h8481;
    model();
    done_seen = 0;
    start_run(4);
    feed();
    checks++;
    if ({pass, byte_err, err_cnt, first_err_valid, first_err_beat} !== {1'b0, 2'b01, 2'd1, 1'b1, 16'd2}) begin
      failures++;
      $display("FAIL lane_error got=%h expected=%h", {pass, byte_err, err_cnt, first_err_valid, first_err_beat}, {1'b0, 2'b01, 2'd1, 1'b1, 16'd2});
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL lane_error_done got=%b expected=1", done);
    end
  endtask

  task automatic test_gapped();
    gap_max = 3;
    good_list(4);
    done_seen = 0;
    start_run(4);
    feed();
    gap_max = 0;
    checks++;
    if ({done, pass, byte_err, err_cnt} !== {1'b1, 1'b1, NL'(0), EW'(0)}) begin
      failures++;
      $display("FAIL gapped got done=%b pass=%b be=%b cnt=%0d expected done=1 pass=1 be=0 cnt=0", done, pass, byte_err, err_cnt);
    end
  endtask

  task automatic test_abort();
    done_seen = 0;
    good_list(2);
    start_run(4);
    feed();
    good_list(4);
    start_run(4);
    feed();
    repeat (2) @(negedge clk);
    checks++;
    if ({done_seen, pass, byte_err} !== {32'd1, 1'b1, NL'(0)}) begin
      failures++;
      $display("FAIL abort_restart got dones=%0d pass=%b be=%b expected dones=1 pass=1 be=0", done_seen, pass, byte_err);
    end
    done_seen = 0;
    good_list(1);
    start_run(2);
    feed();
    rdata_valid = 1'b1;
    rdata = good_beat(1);
    start = 1'b1;
    num_beats = 16'd4;
    @(negedge clk);
    start = 1'b0;
    rdata_valid = 1'b0;
    good_list(4);
    feed();
    repeat (2) @(negedge clk);
    checks++;
    if ({done_seen, pass, busy} !== {32'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL start_on_last_beat got dones=%0d pass=%b busy=%b expected dones=1 pass=1 busy=0", done_seen, pass, busy);
    end
  endtask

  task automatic test_saturation();
    beats.delete();
    repeat (5) beats.push_back('0);
    model();
    start_run(5);
    feed();
    checks++;
    if ({err_cnt, byte_err, first_err_beat, pass} !== {2'd3, 2'b11, 16'd0, 1'b0} ||
        {err_cnt, byte_err, first_err_beat, pass} !== {EW'(m_cnt), m_be, 16'(m_feb), m_pass}) begin
      failures++;
      $display("FAIL saturation got cnt=%0d be=%b feb=%0d pass=%b expected cnt=3 be=11 feb=0 pass=0", err_cnt, byte_err, first_err_beat, pass);
    end
  endtask

  task automatic test_reset_mid();
    beats.delete();
    beats.push_back('0);
    start_run(4);
    feed();
    checks++;
    if ({busy, first_err_valid} !== 2'b11) begin
      failures++;
      $display("FAIL reset_mid_pre got busy,fev=%b expected 11", {busy, first_err_valid});
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, first_err_valid, byte_err, err_cnt, first_err_beat} !== '0) begin
      failures++;
      $display("FAIL reset_mid got=%h expected=0", {busy, done, pass, first_err_valid, byte_err, err_cnt, first_err_beat});
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_zero_len();
    done_seen = 0;
    start_run(0);
    checks++;
    if ({done, pass, busy, err_cnt, first_err_valid} !== {1'b1, 1'b1, 1'b0, EW'(0), 1'b0}) begin
      failures++;
      $display("FAIL zero_len got done=%b pass=%b busy=%b cnt=%0d fev=%b expected 1 1 0 0 0", done, pass, busy, err_cnt, first_err_valid);
    end
    rdata_valid = 1'b1;
    rdata = '0;
    repeat (2) @(negedge clk);
    rdata_valid = 1'b0;
    checks++;
    if ({done_seen, done, pass, err_cnt} !== {32'd1, 1'b0, 1'b1, EW'(0)}) begin
      failures++;
      $display("FAIL zero_len_hold got dones=%0d done=%b pass=%b cnt=%0d expected 1 0 1 0", done_seen, done, pass, err_cnt);
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 8);
      gap_max = $urandom_range(0, 2);
      beats.delete();
      for (int k = 0; k < n; k++)
        beats.push_back($urandom_range(3) == 0 ? good_beat(k) ^ DW'($urandom_range(1, 65535)) : good_beat(k));
      model();
      done_seen = 0;
      start_run(n);
      feed();
      checks++;
      if ({done, busy, pass, byte_err, err_cnt, first_err_valid} !== {1'b1, 1'b0, m_pass, m_be, EW'(m_cnt), m_fev} ||
          (m_fev && first_err_beat !== 16'(m_feb))) begin
        failures++;
        $display("FAIL random_run%0d got done=%b busy=%b pass=%b be=%b cnt=%0d fev=%b feb=%0d expected 1 0 %b %b %0d %b %0d",
                 r, done, busy, pass, byte_err, err_cnt, first_err_valid, first_err_beat, m_pass, m_be, m_cnt, m_fev, m_feb);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done_seen !== 1) begin
        failures++;
        $display("FAIL random_done_count%0d got=%0d expected=1", r, done_seen);
      end
    end
    gap_max = 0;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_lane_error();
    test_gapped();
    test_abort();
    test_saturation();
    test_reset_mid();
    test_zero_len();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ddr2_sdram_ex_lfsr_checker.md
Name: ddr2_sdram_ex_lfsr_checker

Overview:
Read-data checker for the DDR2 example driver. It sits downstream of the memory read path and consumes read beats. For each beat it regenerates the expected pseudo-random pattern, one 8-bit LFSR per byte lane, and compares it with the returned data. It reports pass/fail, per-lane sticky error flags, an error-beat count and the index of the first failing beat to the driver FSM and the status LEDs.

Parameters:
DATA_WIDTH, 64, read data width; must be a multiple of 8; NUM_LANES = DATA_WIDTH/8.
SEED, 32, base seed; lane i seed = (SEED + i) mod 256.
ERR_CNT_WIDTH, 16, width of the error-beat counter; the counter saturates.

Ports:
clk  in  1  clock
reset_n  in  1  reset
start  in  1  one-cycle pulse; starts or restarts a check run
num_beats  in  16  beats to check this run; sampled on start
rdata_valid  in  1  read beat valid
rdata  in  DATA_WIDTH  read beat; lane i = rdata[8i+7:8i]
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
pass  out  1  run completed with zero mismatches; held until next start
byte_err  out  NUM_LANES  sticky per-lane mismatch flags
err_cnt  out  ERR_CNT_WIDTH  count of beats with at least one mismatching lane; saturating
first_err_valid  out  1  first_err_beat is meaningful
first_err_beat  out  16  beat index of first mismatch

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - FSM to IDLE; all lane LFSRs to their seeds.
  - busy, done, pass, first_err_valid = 0; byte_err, err_cnt, first_err_beat, beat counter = 0.
- LFSR step (per lane, polynomial x^8+x^4+x^3+x^2+1), with n = next, c = current:
  - n0=c7; n1=c0; n2=c1^c7; n3=c2^c7; n4=c3^c7; n5=c4; n6=c5; n7=c6.
  - Lane advances exactly once per accepted beat; holds otherwise.
- FSM states: IDLE, CHECK, FIN.
  - IDLE/FIN + start: reload all lane seeds, latch num_beats, clear byte_err/err_cnt/first_err*/beat counter, pass=0, busy=1, go CHECK.
  - start with num_beats=0: go FIN directly; done pulses the next cycle with pass=1.
  - CHECK + rdata_valid:
    - Compare rdata lane i against current expected lane i.
    - Mismatch on lane i sets byte_err[i].
    - Any mismatch: err_cnt+1, saturating at all-ones.
    - First mismatch of the run: first_err_beat = current beat index, first_err_valid=1.
    - Then advance the LFSRs and increment the beat counter.
  - Flags update 1 cycle after the beat is presented (registered compare).
  - CHECK, valid beat with index num_beats-1: go FIN. The next cycle asserts done=1 for one cycle, busy=0, pass = (no mismatch in run including last beat).
  - FIN: all outputs hold. rdata_valid ignored.
- rdata_valid in IDLE/FIN: ignored; LFSRs do not advance.
- start during CHECK: abort and restart as from IDLE. No done pulse for the aborted run.
- start coincident with the last beat: start wins; the last beat is discarded and no done pulse is issued.
- Asynchronous reset mid-run: immediate return to reset values.

Decomposition:
- Shared package: LFSR polynomial tap mask constant (8'h1D), LANE_W=8, FSM state encoding (IDLE/CHECK/FIN).
- One natural sub-module: ddr2_sdram_ex_exp_lane.
  - Single 8-bit expected-data LFSR with per-lane seed parameter and ports load, advance, data.
  - Instantiated NUM_LANES times with a generate loop.

Test Plan (DATA_WIDTH=16, SEED=32; expected lane0 sequence 0x20,0x40,0x80,0x1D; lane1 sequence 0x21,0x42,0x84,0x15):
- Clean run: start with num_beats=4; beats 0x2120,0x4240,0x8480,0x151D -> done pulse 1 cycle after beat 3, pass=1, byte_err=00, err_cnt=0, first_err_valid=0.
- Single-lane error: same run but beat 2 = 0x8481 -> pass=0, byte_err=01, err_cnt=1, first_err_beat=2.
- Gapped valid: same 4 correct beats with 0–3 idle cycles between them -> pass=1; LFSRs hold through gaps.
- Abort and restart: start, 2 good beats, start again with num_beats=4 plus 4 correct beats from seed -> single done pulse, pass=1.
- Saturation: ERR_CNT_WIDTH=2, 5 all-wrong beats (0x0000) -> err_cnt=3, byte_err=11, first_err_beat=0.
- Reset mid-run after 1 beat -> all outputs return to reset values.
- Zero-length run: start with num_beats=0 -> done pulse with pass=1 and no beats consumed.
